pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. Decides every cycle whether the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers advance, hold, take a bubble or flush. Priority order is:
1. Data-memory wait.
2. Load-use hazard.
3. Taken branch/jump.

Sits beside the hazard unit's register-number taps and drives the write-enables of the PC and the pipeline registers.

---
 rtl/pipeline_ctrl_pkg.sv | 44 ++++
 rtl/pipeline_ctrl_if.sv | 36 +++
 rtl/pipeline_ctrl_load_use.sv | 17 +
 rtl/pipeline_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  localparam int REG_W       = 5;
  localparam int STALL_CNT_W = 32;
  localparam int FLUSH_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_e;

  // One bundle of pipeline-register enables, decoded once per cycle.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_write;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                  idex_bubble: 1'b1, exmem_write: 1'b0, memwb_bubble: 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                    idex_bubble: 1'b0, exmem_write: 1'b0, memwb_bubble: 1'b1};
  localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                    idex_bubble: 1'b0, exmem_write: 1'b1, memwb_bubble: 1'b0};
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                   idex_bubble: 1'b0, exmem_write: 1'b1, memwb_bubble: 1'b0};
  localparam ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      idex_bubble: 1'b1, exmem_write: 1'b1, memwb_bubble: 1'b0};

  // Enables when memory is not stalling: load-use beats a redirect, since the
  // branch re-resolves once the load result is forwarded.
  function automatic ctrl_t resolve_run(input logic hazard, input logic redirect);
    if (hazard) return CTRL_LOAD_USE;
    if (redirect) return CTRL_FLUSH;
    return CTRL_NORMAL;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard taps, memory handshake and pipeline enables between datapath and sequencer.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic             idex_memread_i;
  logic [REG_W-1:0] idex_rt_i;
  logic [REG_W-1:0] ifid_rs_i;
  logic [REG_W-1:0] ifid_rt_i;
  logic             ifid_uses_rt_i;
  logic             branch_taken_i;
  logic             jump_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             exmem_write_o;
  logic             memwb_bubble_o;

  // Datapath side: supplies hazard/memory status, consumes enables.
  modport master (
    output idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
           branch_taken_i, jump_i, dmem_req_i, dmem_ack_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           exmem_write_o, memwb_bubble_o
  );

  // Sequencer side.
  modport slave (
    input  idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
           branch_taken_i, jump_i, dmem_req_i, dmem_ack_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           exmem_write_o, memwb_bubble_o
  );
endinterface

// File: rtl/pipeline_ctrl_load_use.sv
// Register-number compare between a load in EX and the instruction in ID.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  output logic             hazard
);

  // $zero never carries a loaded value, so a load to r0 cannot cause a hazard.
  assign hazard = idex_memread_i && (idex_rt_i != '0) &&
                  ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: drives PC and pipeline-register enables every cycle.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  pipeline_ctrl_if.slave         bus,
  output logic                   mem_err_o,
  output logic [1:0]             state_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic [FLUSH_CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                   mem_err_q, mem_err_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  ctrl_t                  ctrl;
  logic                   hazard;
  logic                   redirect;
  logic                   mem_stall;

  load_use_detect u_load_use (
    .idex_memread_i (bus.idex_memread_i),
    .idex_rt_i      (bus.idex_rt_i),
    .ifid_rs_i      (bus.ifid_rs_i),
    .ifid_rt_i      (bus.ifid_rt_i),
    .ifid_uses_rt_i (bus.ifid_uses_rt_i),
    .hazard         (hazard)
  );

  assign redirect  = bus.branch_taken_i || bus.jump_i;
  assign mem_stall = bus.dmem_req_i && !bus.dmem_ack_i;

  // Next-state, wait-counter and enable decode; memory stall outranks everything.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    ctrl       = CTRL_IDLE;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (mem_stall) begin
          ctrl       = CTRL_FREEZE;
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          ctrl = resolve_run(hazard, redirect);
          if (!start_i) state_d = IDLE;
        end
      end
      MEM_WAIT: begin
        // start_i is deliberately not looked at until the access completes.
        if (!bus.dmem_ack_i) begin
          ctrl = CTRL_FREEZE;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d   = HALT;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          ctrl       = resolve_run(hazard, redirect);
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      default: ctrl = CTRL_IDLE;  // HALT: parked until reset
    endcase
  end

  // Saturating stall and flush statistics.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == RUN || state_q == MEM_WAIT) && !ctrl.pc_write && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    if (ctrl.ifid_flush && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + FLUSH_CNT_W'(1);
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_i) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_write_o     = ctrl.pc_write;
  assign bus.ifid_write_o   = ctrl.ifid_write;
  assign bus.ifid_flush_o   = ctrl.ifid_flush;
  assign bus.idex_bubble_o  = ctrl.idex_bubble;
  assign bus.exmem_write_o  = ctrl.exmem_write;
  assign bus.memwb_bubble_o = ctrl.memwb_bubble;
  assign mem_err_o          = mem_err_q;
  assign state_o            = state_q;
  assign stall_cnt_o        = stall_cnt_q;
  assign flush_cnt_o        = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each driven cycle pushes its expected
// enables/state/counters; a negedge monitor pops and compares.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  // Enable vectors: {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_bubble}
  localparam logic [5:0] C_IDLE   = 6'b000101;
  localparam logic [5:0] C_FREEZE = 6'b000001;
  localparam logic [5:0] C_NORM   = 6'b110010;
  localparam logic [5:0] C_FLUSH  = 6'b111010;
  localparam logic [5:0] C_LU     = 6'b000110;

  typedef struct {
    string       name;
    state_e      st;
    logic [5:0]  c;
    logic        err;
    logic [31:0] stall;
    logic [15:0] flush;
  } exp_t;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic        mem_err_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] exp_stall = '0;
  logic [15:0] exp_flush = '0;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .bus         (bus),
    .mem_err_o   (mem_err_o),
    .state_o     (state_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the expectation queued for this cycle, mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [5:0] got_c;
      e = sb.pop_front();
      got_c = {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o,
               bus.idex_bubble_o, bus.exmem_write_o, bus.memwb_bubble_o};
      checks++;
      if ({state_o, got_c, mem_err_o} !== {e.st, e.c, e.err}) begin
        errors++;
        $display("FAIL %s state/enables/err got %0d/%b/%b exp %0d/%b/%b",
                 e.name, state_o, got_c, mem_err_o, e.st, e.c, e.err);
      end
      checks++;
      if (stall_cnt_o !== e.stall) begin
        errors++;
        $display("FAIL %s stall_cnt got %0d exp %0d", e.name, stall_cnt_o, e.stall);
      end
      checks++;
      if (flush_cnt_o !== e.flush) begin
        errors++;
        $display("FAIL %s flush_cnt got %0d exp %0d", e.name, flush_cnt_o, e.flush);
      end
    end
  end

  // Queue the expectation for the current inputs, advance the bench's counter
  // model by the expected enables, then move to just after the next edge.
  task automatic step(input string name, input state_e st, input logic [5:0] c, input logic err);
    exp_t e;
    e.name = name; e.st = st; e.c = c; e.err = err;
    e.stall = exp_stall; e.flush = exp_flush;
    sb.push_back(e);
    if (!rst_i) begin
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      if ((st == RUN || st == MEM_WAIT) && !c[5] && exp_stall != '1) exp_stall++;
      if (c[3] && exp_flush != '1) exp_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.idex_memread_i = 1'b0;
    bus.idex_rt_i      = '0;
    bus.ifid_rs_i      = '0;
    bus.ifid_rt_i      = '0;
    bus.ifid_uses_rt_i = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.jump_i         = 1'b0;
    bus.dmem_req_i     = 1'b0;
    bus.dmem_ack_i     = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    start_i = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    step("reset_0", IDLE, C_IDLE, 1'b0);
    step("reset_1", IDLE, C_IDLE, 1'b0);
    rst_i = 1'b1;
    start_i = 1'b1;
    step("start_idle", IDLE, C_IDLE, 1'b0);
    step("start_run", RUN, C_NORM, 1'b0);
    checks++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] base;
    base = stall_cnt_o;
    bus.idex_memread_i = 1'b1; bus.idex_rt_i = 5'd8; bus.ifid_rs_i = 5'd8;
    bus.branch_taken_i = 1'b1;
    step("lu_rs", RUN, C_LU, 1'b0);
    clear_inputs();
    step("lu_clear", RUN, C_NORM, 1'b0);
    checks++;
    if (stall_cnt_o !== base + 32'd1) begin
      errors++;
      $display("FAIL lu_stall_cnt got %0d exp %0d", stall_cnt_o, base + 32'd1);
    end
    bus.idex_memread_i = 1'b1; bus.idex_rt_i = 5'd8; bus.ifid_rs_i = 5'd3;
    bus.ifid_rt_i = 5'd8; bus.ifid_uses_rt_i = 1'b1;
    step("lu_rt", RUN, C_LU, 1'b0);
    bus.ifid_uses_rt_i = 1'b0;
    step("lu_rt_unused", RUN, C_NORM, 1'b0);
    bus.idex_rt_i = 5'd0; bus.ifid_rs_i = 5'd0; bus.ifid_rt_i = 5'd0;
    bus.ifid_uses_rt_i = 1'b1; bus.branch_taken_i = 1'b1;
    step("lu_r0", RUN, C_FLUSH, 1'b0);
    clear_inputs();
    checks++;
    if (stall_cnt_o !== base + 32'd2) begin
      errors++;
      $display("FAIL lu_total_stalls got %0d exp %0d", stall_cnt_o, base + 32'd2);
    end
  endtask

  task automatic test_branch();
    logic [15:0] base;
    base = flush_cnt_o;
    bus.branch_taken_i = 1'b1;
    step("br_taken", RUN, C_FLUSH, 1'b0);
    bus.branch_taken_i = 1'b0; bus.jump_i = 1'b1;
    step("br_jump", RUN, C_FLUSH, 1'b0);
    clear_inputs();
    step("br_none", RUN, C_NORM, 1'b0);
    checks++;
    if (flush_cnt_o !== base + 16'd2) begin
      errors++;
      $display("FAIL br_flush_cnt got %0d exp %0d", flush_cnt_o, base + 16'd2);
    end
  endtask

  task automatic test_mem_wait();
    logic [31:0] base;
    base = stall_cnt_o;
    bus.dmem_req_i = 1'b1;
    step("mw_req", RUN, C_FREEZE, 1'b0);
    start_i = 1'b0;  // ignored while the access is outstanding
    step("mw_1", MEM_WAIT, C_FREEZE, 1'b0);
    step("mw_2", MEM_WAIT, C_FREEZE, 1'b0);
    bus.dmem_ack_i = 1'b1;
    step("mw_ack", MEM_WAIT, C_NORM, 1'b0);
    clear_inputs();
    step("mw_run_stop", RUN, C_NORM, 1'b0);
    checks++;
    if (stall_cnt_o !== base + 32'd3) begin
      errors++;
      $display("FAIL mw_stall_cnt got %0d exp %0d", stall_cnt_o, base + 32'd3);
    end
    start_i = 1'b1;
    step("mw_idle", IDLE, C_IDLE, 1'b0);
    step("mw_rerun", RUN, C_NORM, 1'b0);
    bus.dmem_req_i = 1'b1; bus.dmem_ack_i = 1'b1;
    step("mw_first_ack", RUN, C_NORM, 1'b0);
    clear_inputs();
    checks++;
    if (stall_cnt_o !== base + 32'd3) begin
      errors++;
      $display("FAIL mw_no_stall_on_ack got %0d exp %0d", stall_cnt_o, base + 32'd3);
    end
  endtask

  task automatic test_priority();
    bus.dmem_req_i = 1'b1;
    bus.idex_memread_i = 1'b1; bus.idex_rt_i = 5'd5; bus.ifid_rs_i = 5'd5;
    bus.branch_taken_i = 1'b1;
    step("pri_mem_masks", RUN, C_FREEZE, 1'b0);
    bus.dmem_ack_i = 1'b1;
    step("pri_ack_lu", MEM_WAIT, C_LU, 1'b0);
    bus.idex_memread_i = 1'b0; bus.dmem_req_i = 1'b0; bus.dmem_ack_i = 1'b0;
    step("pri_branch", RUN, C_FLUSH, 1'b0);
    clear_inputs();
  endtask

  task automatic test_saturation();
    rst_i = 1'b0;
    step("sat_rst", RUN, C_NORM, 1'b0);
    rst_i = 1'b1;
    step("sat_idle", IDLE, C_IDLE, 1'b0);
    step("sat_run", RUN, C_NORM, 1'b0);
    bus.branch_taken_i = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    exp_flush = 16'hFFFE;
    checks++;
    if (flush_cnt_o !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preload got %h exp fffe", flush_cnt_o);
    end
    for (int i = 0; i < 3; i++) step("sat_flush", RUN, C_FLUSH, 1'b0);
    clear_inputs();
    step("sat_hold", RUN, C_NORM, 1'b0);
    checks++;
    if (flush_cnt_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_final got %h exp ffff", flush_cnt_o);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] base;
    base = stall_cnt_o;
    bus.dmem_req_i = 1'b1;
    step("to_req", RUN, C_FREEZE, 1'b0);
    for (int i = 0; i < 4; i++) step("to_wait", MEM_WAIT, C_FREEZE, 1'b0);
    bus.dmem_ack_i = 1'b1;
    start_i = 1'b1;
    step("to_halt_0", HALT, C_IDLE, 1'b1);
    step("to_halt_1", HALT, C_IDLE, 1'b1);
    checks++;
    if (stall_cnt_o !== base + 32'd5) begin
      errors++;
      $display("FAIL to_stall_cnt got %0d exp %0d", stall_cnt_o, base + 32'd5);
    end
    rst_i = 1'b0;
    step("to_rst_edge", HALT, C_IDLE, 1'b1);
    rst_i = 1'b1;
    start_i = 1'b0;
    clear_inputs();
    step("to_after_rst", IDLE, C_IDLE, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_priority();
    test_saturation();
    test_timeout();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
